// File: rtl/viterbi_pkg.sv
// Shared code definition for the FEC chain: constraint length and generators.
// Encoder, decoder and speed mapper all import these defaults.
package viterbi_pkg;

    localparam int             code_k       = 7;
    localparam logic [code_k-1:0] code_poly_0  = 7'b1001111;
    localparam logic [code_k-1:0] code_poly_1  = 7'b1101101;
    localparam logic [code_k-1:0] code_state_0 = 7'b0000000;

endpackage

// File: rtl/viterbi_parity.sv
// Masked XOR-reduce of a K-bit window against one generator polynomial.
module viterbi_parity
    import viterbi_pkg::*;
#(
    parameter int p_width = code_k
) (
    input  logic [p_width-1:0] window,
    input  logic [p_width-1:0] polinom,
    output logic               parity
);

    assign parity = ^(window & polinom);

endmodule

// File: rtl/viterbi_conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder, one registered symbol per bit.
module viterbi_conv_encoder
    import viterbi_pkg::*;
#(
    parameter int                      p_size_polinom  = code_k,
    parameter logic [p_size_polinom-1:0] p_polinom_0     = code_poly_0,
    parameter logic [p_size_polinom-1:0] p_polinom_1     = code_poly_1,
    parameter logic [p_size_polinom-1:0] p_defoult_state = code_state_0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_data,
    input  logic       i_valid,
    output logic [1:0] o_data,
    output logic       o_valid
);

    logic [p_size_polinom-1:0] st;
    logic [p_size_polinom-1:0] window;
    logic                      c0;
    logic                      c1;

    // newest bit at the MSB, oldest drops off the LSB
    assign window = {i_data, st[p_size_polinom-1:1]};

    viterbi_parity #(.p_width(p_size_polinom)) u_par0 (
        .window (window),
        .polinom(p_polinom_0),
        .parity (c0)
    );

    viterbi_parity #(.p_width(p_size_polinom)) u_par1 (
        .window (window),
        .polinom(p_polinom_1),
        .parity (c1)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st      <= p_defoult_state;
            o_data  <= 2'b00;
            o_valid <= 1'b0;
        end else if (i_valid) begin
            st      <= window;
            o_data  <= {c1, c0};
            o_valid <= 1'b1;
        end else begin
            o_data  <= 2'b00;
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_conv_encoder.sv
// Bench for viterbi_conv_encoder: history-queue model plus literal checks.
module tb_viterbi_conv_encoder;

    localparam int K = 7;
    localparam logic [K-1:0] G0 = 7'b1001111;
    localparam logic [K-1:0] G1 = 7'b1101101;
    localparam logic [K-1:0] DEF_B = 7'b1000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic vin = 1'b0;
    logic [1:0] a_data, b_data;
    logic a_valid, b_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    viterbi_conv_encoder dut_a (
        .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid(vin),
        .o_data(a_data), .o_valid(a_valid)
    );

    viterbi_conv_encoder #(.p_defoult_state(DEF_B)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid(vin),
        .o_data(b_data), .o_valid(b_valid)
    );

    // past[d-1] is the information bit d steps ago
    bit past_a[$];
    bit past_b[$];
    logic [1:0] exp_a_d, exp_b_d;
    logic exp_v;
    bit started = 0;
    bit capture = 0;
    logic [1:0] cap[$];

    function automatic void init_past(output bit p[$], input logic [K-1:0] def);
        p = {};
        for (int d = 1; d < K; d++) p.push_back(def[K-d]);
    endfunction

    function automatic logic [1:0] code(input bit cur, input bit p[$]);
        logic [K-1:0] g0, g1;
        bit b, c0, c1;
        g0 = G0;
        g1 = G1;
        c0 = 0;
        c1 = 0;
        for (int d = 0; d < K; d++) begin
            b = (d == 0) ? cur : p[d-1];
            c0 = c0 ^ (b & g0[K-1-d]);
            c1 = c1 ^ (b & g1[K-1-d]);
        end
        return {c1, c0};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            init_past(past_a, '0);
            init_past(past_b, DEF_B);
            exp_v   = 1'b0;
            exp_a_d = 2'b00;
            exp_b_d = 2'b00;
        end else if (vin) begin
            exp_v   = 1'b1;
            exp_a_d = code(din, past_a);
            exp_b_d = code(din, past_b);
            past_a.push_front(din);
            past_a = past_a[0:K-2];
            past_b.push_front(din);
            past_b = past_b[0:K-2];
        end else begin
            exp_v   = 1'b0;
            exp_a_d = 2'b00;
            exp_b_d = 2'b00;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (a_valid !== exp_v || a_data !== exp_a_d) begin
                errors++;
                $display("FAIL model_a t=%0t got v=%b d=%b want v=%b d=%b",
                         $time, a_valid, a_data, exp_v, exp_a_d);
            end
            checks++;
            if (b_valid !== exp_v || b_data !== exp_b_d) begin
                errors++;
                $display("FAIL model_b t=%0t got v=%b d=%b want v=%b d=%b",
                         $time, b_valid, b_data, exp_v, exp_b_d);
            end
            if (capture && a_valid) cap.push_back(a_data);
        end
    end

    task automatic step(input logic r, input logic v, input logic d);
        rst = r;
        vin = v;
        din = d;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [2:0] got,
                       input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got v,d=%b want %b", name, got, want);
        end
    endtask

    logic [10:0] word = 11'b11001111010;
    logic [1:0] ref_syms[$];
    int gap_pos[3];

    initial begin
        step(1, 0, 0);
        step(1, 0, 0);
        started = 1;
        lit("reset_a", {a_valid, a_data}, 3'b000);
        lit("reset_b", {b_valid, b_data}, 3'b000);

        step(0, 1, 0);
        lit("first_zero_a", {a_valid, a_data}, 3'b100);
        lit("def_nonzero_b", {b_valid, b_data}, 3'b110);
        step(0, 1, 1);
        lit("bit1_a", {a_valid, a_data}, 3'b111);
        step(0, 1, 1);
        lit("bit2_a", {a_valid, a_data}, 3'b101);
        step(0, 0, 1);
        lit("idle_a", {a_valid, a_data}, 3'b000);

        // gapless word, LSB first, two tail zeros
        step(1, 0, 0);
        capture = 1;
        for (int i = 0; i < 11; i++) step(0, 1, word[i]);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        capture = 0;
        ref_syms = cap;
        cap = {};
        checks++;
        if (ref_syms.size() != 13) begin
            errors++;
            $display("FAIL word_count got %0d want 13", ref_syms.size());
        end

        // same word with three idle cycles inserted
        for (int g = 0; g < 3; g++) gap_pos[g] = $urandom_range(1, 11);
        step(1, 0, 0);
        capture = 1;
        for (int i = 0; i < 13; i++) begin
            for (int g = 0; g < 3; g++)
                if (gap_pos[g] == i) begin
                    step(0, 0, 1);
                    lit("gap_a", {a_valid, a_data}, 3'b000);
                end
            step(0, 1, (i < 11) ? word[i] : 1'b0);
        end
        step(0, 0, 0);
        capture = 0;
        checks++;
        if (cap != ref_syms) begin
            errors++;
            $display("FAIL gap_stream got %0d syms differing from %0d",
                     cap.size(), ref_syms.size());
        end

        // reset mid-stream, then reset colliding with valid
        step(0, 1, 1);
        step(0, 1, 0);
        step(1, 0, 0);
        lit("mid_reset_a", {a_valid, a_data}, 3'b000);
        step(0, 1, 1);
        lit("after_reset_a", {a_valid, a_data}, 3'b111);
        step(0, 1, 1);
        step(1, 1, 1);
        lit("rst_wins_a", {a_valid, a_data}, 3'b000);
        lit("rst_wins_b", {b_valid, b_data}, 3'b000);
        step(0, 1, 0);
        lit("post_rst_a", {a_valid, a_data}, 3'b100);
        lit("post_rst_b", {b_valid, b_data}, 3'b110);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
